bmp_pixel_reader: RTL and testbench
===================================

BMP_PIXEL_READER -- requirements
Module: bmp_pixel_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default `ADDR_WIDTH (DEFINE.vh): width of RAM_addr.
REQ-002 Parameter BYTE_WIDTH, default `BYTE_WIDTH (8): width of RAM data and pix_data.
REQ-003 Parameter TOTAL_SIZE, default `BMP_TOTAL_SIZE: number of bytes in the image RAM.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to parse the stored BMP and stream its pixels.
REQ-007 RAM_ren  output  1  RAM read enable.
REQ-008 RAM_wen  output  1  RAM write enable, tied 0.
REQ-009 RAM_addr  output  ADDR_WIDTH  RAM byte address.
REQ-010 RAM_out  input  BYTE_WIDTH  RAM read data, combinationally valid while RAM_ren=1 and RAM_wen=0.
REQ-011 pix_valid  output  1  pix_data holds a pixel byte.
REQ-012 pix_ready  input  1  downstream accepts pix_data.
REQ-013 pix_data  output  BYTE_WIDTH  pixel byte in file order (B,G,R; bottom row first).
REQ-014 pix_last  output  1  high with the final pixel byte.
REQ-015 img_width, img_height  output  16 each  parsed dimensions, held until the next start.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done, error  output  1 each  one-cycle completion / rejection pulses.

Function
REQ-018 States: IDLE, HDR, CHECK, PIX, DONE, ERR.
REQ-019 IDLE -> HDR when start=1; start SHALL be ignored in all other states.
REQ-020 HDR: RAM_ren=1; RAM_addr steps 0..53, one per cycle; RAM_out captured each cycle; after addr 53 -> CHECK.
REQ-021 Captured fields, little-endian: sig = bytes 0-1, offset = bytes 10-13, width = bytes 18-21, height = bytes 22-25, bpp = bytes 28-29.
REQ-022 CHECK (1 cycle, RAM_ren=0) -> ERR if sig != 0x42,0x4D; bpp != 24; width or height = 0; width or height bytes 2-3 != 0; offset < 54; or offset + row_bytes*height > TOTAL_SIZE. Otherwise -> PIX.
REQ-023 row_bytes = (width*3 + 3) rounded down to a multiple of 4; arithmetic SHALL be at least 34 bits wide, with no overflow.
REQ-024 PIX: RAM_ren=1; pix_valid=1; pix_data=RAM_out; first address = offset.
REQ-025 A transfer occurs on a cycle with pix_valid & pix_ready; RAM_addr advances only on a transfer; RAM_addr and pix_data hold while pix_ready=0.
REQ-026 After width*3 transfers in a row, RAM_addr skips the row_bytes - width*3 padding bytes to the next row start, so padding is never output.
REQ-027 pix_last=1 only on byte width*3*height; its transfer -> DONE.
REQ-028 DONE: done=1 for one cycle -> IDLE. ERR: error=1 for one cycle -> IDLE; no pix_valid occurs for a rejected image.
REQ-029 pix_valid=0, pix_data=0, and pix_last=0 outside PIX; RAM_addr=0 and RAM_ren=0 outside HDR and PIX.
REQ-030 Timing: with start sampled at edge E0, first pix_valid=1 occurs in the 56th cycle after E0 (54 HDR + 1 CHECK).
REQ-031 img_width and img_height update in CHECK, on both pass and fail.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, all outputs 0, and all counters and fields 0, including in mid-HDR or mid-PIX; no done or error pulse results.
REQ-033 After rst_n returns high, the block waits for a new start.

Verification
REQ-034 Valid 2x2 24bpp image, offset 54, pix_ready=1 -> 12 bytes from addrs 54-59 and 62-67 (60-61 skipped), pix_last on the 12th, done pulse, img_width=2, img_height=2.
REQ-035 Bytes 0-1 = 0x42,0x4E -> error pulse 55 cycles after start, pix_valid never high, busy low afterwards.
REQ-036 bpp=8 or width=0x00010000 -> error pulse, no pixel output.
REQ-037 Valid 1x1 image, pix_ready low for 3 cycles on the 2nd byte -> RAM_addr=55 and pix_data held for 3 cycles, then 3 bytes total with pix_last on the 3rd.
REQ-038 rst_n pulsed low during PIX after 5 transfers -> outputs 0 at once, no done; a restart then streams the full image from the offset.
REQ-039 offset + row_bytes*height = TOTAL_SIZE+1 -> error; exactly TOTAL_SIZE -> accepted and fully streamed.

Source files
------------

// File: rtl/bmp_pixel_reader.sv
// Parses a 24-bpp BMP header from a byte RAM, validates it, then streams the
// pixel bytes (row padding removed) over a valid/ready interface.
module bmp_pixel_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int TOTAL_SIZE = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  RAM_ren,
  output logic                  RAM_wen,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  input  logic [BYTE_WIDTH-1:0] RAM_out,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [BYTE_WIDTH-1:0] pix_data,
  output logic                  pix_last,
  output logic [15:0]           img_width,
  output logic [15:0]           img_height,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_dbg
);

  // Pixel handshake: a byte moves on any rising edge where pix_valid and
  // pix_ready are both high; while pix_ready is low, RAM_addr and pix_data hold.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    CHECK = 3'd2,
    PIX   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] sig;
  logic [31:0] offset;
  logic [31:0] width;
  logic [31:0] height;
  logic [15:0] bpp;
  logic [17:0] row_len;
  logic [1:0]  pad;
  logic [17:0] col_cnt;
  logic [15:0] row_cnt;

  logic [63:0] w3;
  logic [63:0] row_bytes;
  logic [63:0] need;
  logic        hdr_bad;
  logic        row_end;
  logic        last_byte;

  // Wide arithmetic so offset + row_bytes*height can never wrap.
  always_comb begin
    w3        = {48'd0, width[15:0]} * 64'd3;
    row_bytes = (w3 + 64'd3) & ~64'd3;
    need      = {32'd0, offset} + row_bytes * {48'd0, height[15:0]};
    hdr_bad   = (sig != 16'h4D42) || (bpp != 16'd24) ||
                (width[15:0] == 16'd0) || (height[15:0] == 16'd0) ||
                (width[31:16] != 16'd0) || (height[31:16] != 16'd0) ||
                (offset < 32'd54) || (need > 64'(TOTAL_SIZE));
  end

  assign row_end   = (col_cnt == row_len - 18'd1);
  assign last_byte = row_end && (row_cnt == img_height - 16'd1);

  assign RAM_ren   = (state == HDR) || (state == PIX);
  assign RAM_wen   = 1'b0;
  assign pix_valid = (state == PIX);
  assign pix_data  = pix_valid ? RAM_out : '0;
  assign pix_last  = pix_valid && last_byte;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      RAM_addr   <= '0;
      sig        <= '0;
      offset     <= '0;
      width      <= '0;
      height     <= '0;
      bpp        <= '0;
      row_len    <= '0;
      pad        <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      img_width  <= '0;
      img_height <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR;
            RAM_addr <= '0;
          end
        end
        HDR: begin
          case (RAM_addr[5:0])
            6'd0:  sig[7:0]      <= RAM_out[7:0];
            6'd1:  sig[15:8]     <= RAM_out[7:0];
            6'd10: offset[7:0]   <= RAM_out[7:0];
            6'd11: offset[15:8]  <= RAM_out[7:0];
            6'd12: offset[23:16] <= RAM_out[7:0];
            6'd13: offset[31:24] <= RAM_out[7:0];
            6'd18: width[7:0]    <= RAM_out[7:0];
            6'd19: width[15:8]   <= RAM_out[7:0];
            6'd20: width[23:16]  <= RAM_out[7:0];
            6'd21: width[31:24]  <= RAM_out[7:0];
            6'd22: height[7:0]   <= RAM_out[7:0];
            6'd23: height[15:8]  <= RAM_out[7:0];
            6'd24: height[23:16] <= RAM_out[7:0];
            6'd25: height[31:24] <= RAM_out[7:0];
            6'd28: bpp[7:0]      <= RAM_out[7:0];
            6'd29: bpp[15:8]     <= RAM_out[7:0];
            default: ;
          endcase
          if (RAM_addr == ADDR_WIDTH'(53)) begin
            RAM_addr <= '0;
            state    <= CHECK;
          end else begin
            RAM_addr <= RAM_addr + ADDR_WIDTH'(1);
          end
        end
        CHECK: begin
          img_width  <= width[15:0];
          img_height <= height[15:0];
          row_len    <= w3[17:0];
          pad        <= row_bytes[1:0] - w3[1:0];
          col_cnt    <= '0;
          row_cnt    <= '0;
          if (hdr_bad) begin
            state <= ERR;
          end else begin
            state    <= PIX;
            RAM_addr <= offset[ADDR_WIDTH-1:0];
          end
        end
        PIX: begin
          if (pix_ready) begin
            if (last_byte) begin
              state    <= DONE;
              RAM_addr <= '0;
              col_cnt  <= '0;
              row_cnt  <= '0;
            end else if (row_end) begin
              // Jump over the row's padding straight to the next row start.
              col_cnt  <= '0;
              row_cnt  <= row_cnt + 16'd1;
              RAM_addr <= RAM_addr + ADDR_WIDTH'(1) + ADDR_WIDTH'(pad);
            end else begin
              col_cnt  <= col_cnt + 18'd1;
              RAM_addr <= RAM_addr + ADDR_WIDTH'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_pixel_reader.sv
// Bench for bmp_pixel_reader: a 128-byte RAM model, directed BMP headers and
// a scoreboard that checks every transferred pixel byte, its address and pix_last.
module tb_bmp_pixel_reader;

  localparam int AW = 16;
  localparam int TS = 128;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          ram_ren;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_out;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic          pix_last;
  logic [15:0]   img_width;
  logic [15:0]   img_height;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    state_dbg;

  logic [7:0]    mem [0:TS-1];
  logic [24:0]   exp_q[$];

  int total = 0;
  int bad = 0;
  int pv_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int xfer_cnt = 0;

  bmp_pixel_reader #(.ADDR_WIDTH(AW), .BYTE_WIDTH(8), .TOTAL_SIZE(TS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .RAM_ren(ram_ren), .RAM_wen(ram_wen), .RAM_addr(ram_addr), .RAM_out(ram_out),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
    .img_width(img_width), .img_height(img_height),
    .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
  );

  // clock / RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_out = (ram_ren && !ram_wen && ram_addr < 16'(TS)) ? mem[ram_addr[6:0]] : 8'h00;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // monitor: pops one expectation per accepted pixel byte
  always @(negedge clk) begin
    if (rst_n && pix_valid) pv_cnt++;
    if (rst_n && done) done_cnt++;
    if (rst_n && error) err_cnt++;
    if (rst_n && pix_valid && pix_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pixel", 64'(ram_addr), 64'hFFFF_FFFF);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        chk("pix_data", 64'(pix_data), 64'(e[7:0]));
        chk("pix_addr", 64'(ram_addr), 64'(e[23:8]));
        chk("pix_last", 64'(pix_last), 64'(e[24]));
      end
    end
  end

  // driver tasks
  task automatic set_hdr(input logic [7:0] sig1, input logic [31:0] off,
                         input logic [31:0] w, input logic [31:0] h, input logic [15:0] bpp);
    for (int a = 0; a < TS; a++) mem[a] = 8'($urandom_range(0, 255));
    mem[0] = 8'h42; mem[1] = sig1;
    for (int i = 0; i < 4; i++) begin
      mem[10+i] = off[8*i +: 8];
      mem[18+i] = w[8*i +: 8];
      mem[22+i] = h[8*i +: 8];
    end
    mem[28] = bpp[7:0]; mem[29] = bpp[15:8];
  endtask

  task automatic push_exp(input int off, input int w, input int h);
    int addr, rb;
    addr = off;
    rb = ((w * 3 + 3) / 4) * 4;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w * 3; c++) begin
        exp_q.push_back({(r == h - 1 && c == w * 3 - 1) ? 1'b1 : 1'b0, 16'(addr), mem[addr]});
        addr++;
      end
      addr += rb - w * 3;
    end
  endtask

  // Issues start and waits (bounded) for done or error; k counts edges after the start edge.
  task automatic do_run(input bit exp_err, input bit check_time);
    int k, first_pv, got_done, got_err, pv0;
    k = 0; first_pv = 0; got_done = 0; got_err = 0; pv0 = pv_cnt;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    while (k < 400 && got_done == 0 && got_err == 0) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (pix_valid && first_pv == 0) first_pv = k;
      if (done) got_done = k;
      if (error) got_err = k;
    end
    if (exp_err) begin
      chk("error_seen", 64'(got_err != 0), 64'd1);
      chk("no_done_on_err", 64'(got_done), 64'd0);
      chk("no_pixels_on_err", 64'(pv_cnt - pv0), 64'd0);
      if (check_time) chk("error_latency", 64'(got_err), 64'd55);
    end else begin
      chk("done_seen", 64'(got_done != 0), 64'd1);
      chk("no_err_on_pass", 64'(got_err), 64'd0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      if (check_time) chk("first_pix_latency", 64'(first_pv), 64'd55);
    end
    @(negedge clk);
    chk("idle_after_run", 64'({busy, done, error, pix_valid, ram_ren}), 64'd0);
  endtask

  task automatic stall_second_byte();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (pix_valid && ram_addr == 16'd54) found = 1'b1;
    end
    chk("stall_found_first_byte", 64'(found), 64'd1);
    if (found) begin
      @(posedge clk);
      #1 pix_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("stall_addr_hold", 64'(ram_addr), 64'd55);
        chk("stall_data_hold", 64'(pix_data), 64'(mem[55]));
      end
      @(posedge clk);
      #1 pix_ready = 1'b1;
    end
  endtask

  initial begin
    int x0, d0, e0;
    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b1;
    for (int a = 0; a < TS; a++) mem[a] = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({ram_ren, ram_wen, pix_valid, pix_last, busy, done, error}), 64'd0);
    chk("reset_addr", 64'(ram_addr), 64'd0);
    chk("reset_dims", 64'({img_width, img_height}), 64'd0);
    chk("reset_state", 64'(state_dbg), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2x2: rows at 54..59 and 62..67
    set_hdr(8'h4D, 32'd54, 32'd2, 32'd2, 16'd24);
    push_exp(54, 2, 2);
    do_run(1'b0, 1'b1);
    chk("img_width_2x2", 64'(img_width), 64'd2);
    chk("img_height_2x2", 64'(img_height), 64'd2);

    // bad signature
    set_hdr(8'h4E, 32'd54, 32'd2, 32'd2, 16'd24);
    do_run(1'b1, 1'b1);

    // 8 bpp, then width with an upper byte set
    set_hdr(8'h4D, 32'd54, 32'd2, 32'd2, 16'd8);
    do_run(1'b1, 1'b0);
    set_hdr(8'h4D, 32'd54, 32'h0001_0000, 32'd2, 16'd24);
    do_run(1'b1, 1'b0);
    chk("img_width_fail_update", 64'(img_width), 64'd0);

    // 1x1 with a 3-cycle stall on the second byte
    set_hdr(8'h4D, 32'd54, 32'd1, 32'd1, 16'd24);
    push_exp(54, 1, 1);
    x0 = xfer_cnt;
    fork
      do_run(1'b0, 1'b1);
      stall_second_byte();
    join
    chk("xfer_count_1x1", 64'(xfer_cnt - x0), 64'd3);
    chk("img_dims_1x1", 64'({img_width, img_height}), {32'd0, 16'd1, 16'd1});

    // reset mid-stream after 5 transfers, then a full restart
    set_hdr(8'h4D, 32'd54, 32'd2, 32'd2, 16'd24);
    push_exp(54, 2, 2);
    x0 = xfer_cnt; d0 = done_cnt; e0 = err_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 200 && xfer_cnt - x0 < 5; i++) @(posedge clk);
    chk("five_xfers_before_reset", 64'(xfer_cnt - x0), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", 64'({ram_ren, pix_valid, pix_last, busy, done, error}), 64'd0);
    chk("reset_mid_addr_data", 64'({ram_addr, pix_data}), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_pulse_after_reset", 64'({done_cnt - d0, err_cnt - e0}), 64'd0);
    chk("idle_after_reset", 64'(busy), 64'd0);
    push_exp(54, 2, 2);
    do_run(1'b0, 1'b1);

    // size boundary: 113+16 = TS+1 rejected, 112+16 = TS accepted
    set_hdr(8'h4D, 32'd113, 32'd2, 32'd2, 16'd24);
    do_run(1'b1, 1'b1);
    set_hdr(8'h4D, 32'd112, 32'd2, 32'd2, 16'd24);
    push_exp(112, 2, 2);
    do_run(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
